// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready stage register with 2-entry skid and flush.
// Optional perf counters enabled by `PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int INS_W = 16,
  parameter int DAT_W = 16,
  parameter int AUX_W = 8,
  parameter logic [INS_W-1:0] NOP_INS = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [DAT_W-1:0] in_dat,
  input  logic [AUX_W-1:0] in_aux,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [DAT_W-1:0] out_dat,
  output logic [AUX_W-1:0] out_aux,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [DAT_W-1:0] dat;
    logic [AUX_W-1:0] aux;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam ent_t NOP_E = {NOP_INS, {DAT_W{1'b0}}, {AUX_W{1'b0}}};

  state_t state, nxt;
  ent_t   main_q, skid_q, in_e;
  logic   rdy_q;
  logic   in_acc, out_acc;
  logic   ld_in, ld_skid, ld_s2m;

  assign in_e      = {in_ins, in_dat, in_aux};
  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign in_acc    = in_valid & rdy_q;
  assign out_acc   = out_valid & out_ready;
  assign out_ins   = main_q.ins;
  assign out_dat   = main_q.dat;
  assign out_aux   = main_q.aux;

  always_comb begin
    nxt     = state;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    ld_s2m  = 1'b0;
    if (flush) begin
      nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_acc) begin
            ld_in = 1'b1;
            nxt   = BUSY;
          end
        end
        BUSY: begin
          if (in_acc && out_acc) begin
            ld_in = 1'b1;
          end else if (in_acc) begin
            ld_skid = 1'b1;
            nxt     = FULL;
          end else if (out_acc) begin
            nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_acc) begin
            ld_s2m = 1'b1;
            nxt    = BUSY;
          end
        end
        default: nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b0;
      main_q <= NOP_E;
      skid_q <= '0;
    end else begin
      state <= nxt;
      rdy_q <= (nxt != FULL);
      if (flush) begin
        main_q <= NOP_E;
        skid_q <= '0;
      end else begin
        if (ld_in) main_q <= in_e;
        else if (ld_s2m) main_q <= skid_q;
        if (ld_skid) skid_q <= in_e;
      end
    end
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic [1:0]       disc;
  logic [CNT_W:0]   fsum;

  // entries lost: unsent main, held skid, and any same-cycle accept
  assign disc = 2'(out_valid & ~out_ready)
              + 2'(state == FULL)
              + 2'(in_acc);
  assign fsum = {1'b0, flush_q} + (CNT_W+1)'(disc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
      if (flush)
        flush_q <= fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed scoreboard bench for pipe_stage_buf.
// Counter expectations follow `PIPE_STAGE_BUF_PERF_EN.
module tb_pipe_stage_buf;

  localparam int CW   = 4;
  localparam int CMAX = 15;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] dat;
    logic [7:0]  aux;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_ins = '0;
  logic [15:0]   in_dat = '0;
  logic [7:0]    in_aux = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_ins;
  logic [15:0]   out_dat;
  logic [7:0]    out_aux;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  ent_t q[$];
  ent_t last;
  bit   exp_rdy;
  int   e_stall, e_flush;
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_stage_buf #(
    .INS_W(16), .DAT_W(16), .AUX_W(8),
    .NOP_INS(16'h0000), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_dat(in_dat), .in_aux(in_aux),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_dat(out_dat), .out_aux(out_aux),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t e;
    e = (q.size() > 0) ? q[0] : last;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, ".out_ins"}, 32'(out_ins), 32'(e.ins));
    chk({tag, ".out_dat"}, 32'(out_dat), 32'(e.dat));
    chk({tag, ".out_aux"}, 32'(out_aux), 32'(e.aux));
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e_flush));
`else
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    last    = '0;
    exp_rdy = 1'b0;
    e_stall = 0;
    e_flush = 0;
  endtask

  task automatic step(input string tag, input bit iv,
                      input logic [15:0] i_ins, input logic [15:0] i_dat,
                      input logic [7:0] i_aux, input bit ordy,
                      input bit fl);
    bit   ia, oa;
    int   d;
    ent_t e;
    in_valid  = iv;
    in_ins    = i_ins;
    in_dat    = i_dat;
    in_aux    = i_aux;
    out_ready = ordy;
    flush     = fl;
    e  = '{ins: i_ins, dat: i_dat, aux: i_aux};
    ia = iv && exp_rdy;
    oa = (q.size() > 0) && ordy;
    if (q.size() > 0 && !ordy && e_stall < CMAX) e_stall++;
    @(posedge clk);
    if (fl) begin
      d = int'(q.size() > 0 && !oa) + int'(q.size() == 2) + int'(ia);
      e_flush = (e_flush + d > CMAX) ? CMAX : e_flush + d;
      q.delete();
      last    = '0;
      exp_rdy = 1'b1;
    end else begin
      if (oa) last = q.pop_front();
      if (ia) q.push_back(e);
      exp_rdy = (q.size() < 2);
    end
    #1 check_all(tag);
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_ins    = 16'($urandom);
      in_dat    = 16'($urandom);
      in_aux    = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 check_all("rst_hold");
    end
    rst = 1'b1;
    step("rst_rel", 1'b1, 16'hFFFF, 16'hFFFF, 8'hFF, 1'b0, 1'b0);
  endtask

  initial begin
    reset_seq();
    step("idle", 1'b0, '0, '0, '0, 1'b1, 1'b0);

    for (int i = 1; i <= 8; i++)
      step("stream", 1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i),
           8'(i), 1'b1, 1'b0);
    step("drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);

    step("bp1", 1'b1, 16'hA001, 16'h0A01, 8'h01, 1'b0, 1'b0);
    step("bp2", 1'b1, 16'hA002, 16'h0A02, 8'h02, 1'b0, 1'b0);
    step("bp3", 1'b1, 16'hA003, 16'h0A03, 8'h03, 1'b0, 1'b0);
    step("bp_hold", 1'b1, 16'hA003, 16'h0A03, 8'h03, 1'b0, 1'b0);
    step("bp_rel1", 1'b1, 16'hA003, 16'h0A03, 8'h03, 1'b1, 1'b0);
    step("bp_rel2", 1'b1, 16'hA003, 16'h0A03, 8'h03, 1'b1, 1'b0);
    step("bp_rel3", 1'b0, '0, '0, '0, 1'b1, 1'b0);
    step("bp_rel4", 1'b0, '0, '0, '0, 1'b1, 1'b0);

    step("fl_fill1", 1'b1, 16'hB001, 16'h0B01, 8'h11, 1'b0, 1'b0);
    step("fl_fill2", 1'b1, 16'hB002, 16'h0B02, 8'h12, 1'b0, 1'b0);
    step("fl_full", 1'b1, 16'hB003, 16'h0B03, 8'h13, 1'b0, 1'b1);
    step("fl_after", 1'b0, '0, '0, '0, 1'b0, 1'b0);

    step("sim_fill", 1'b1, 16'hC001, 16'h0C01, 8'h21, 1'b1, 1'b0);
    step("sim_acc", 1'b1, 16'hC002, 16'h0C02, 8'h22, 1'b1, 1'b1);
    step("sim_fill2", 1'b1, 16'hC003, 16'h0C03, 8'h23, 1'b1, 1'b0);
    step("sim_noin", 1'b0, '0, '0, '0, 1'b1, 1'b1);
    step("sim_idle", 1'b0, '0, '0, '0, 1'b1, 1'b0);

    step("ar_fill1", 1'b1, 16'hD001, 16'h0D01, 8'h31, 1'b0, 1'b0);
    step("ar_fill2", 1'b1, 16'hD002, 16'h0D02, 8'h32, 1'b0, 1'b0);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("ar_async");
    @(posedge clk);
    #1 check_all("ar_hold");
    rst = 1'b1;
    step("ar_rel", 1'b0, '0, '0, '0, 1'b1, 1'b0);

    step("sat_fill", 1'b1, 16'hE001, 16'h0E01, 8'h41, 1'b0, 1'b0);
    repeat (20) step("sat_stall", 1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step("sat_f1", 1'b1, 16'hF000 + 16'(k), 16'h1, 8'h1, 1'b0, 1'b0);
      step("sat_fl", 1'b1, 16'hF100 + 16'(k), 16'h2, 8'h2, 1'b0, 1'b1);
    end
    step("sat_end", 1'b0, '0, '0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
